matc_stream_out: RTL
====================

Name: matc_stream_out

Overview:
- Downstream drain stage for the 8x8 signed matrix-multiply engine.
- Waits for the multiplier's done flag, then reads the 64-entry, 19-bit result matrix C in row-major order through a synchronous read port.
- Streams each element out on a valid/ready interface with row/col tags and a last marker.
- Accumulates a signed checksum and counts drain cycles for lab timing reports.

Parameters:
- N, 8, matrix dimension (rows = cols = N)
- DW, 19, signed element width of matrix C
- AW, 6, C-memory address width (log2(N*N))
- SW, 25, checksum width (DW + AW, sized so no overflow is possible)
- CW, 11, drain cycle counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mm_done  in  1  level done flag from matrix-multiply engine
- c_rd_en  out  1  C-memory read strobe
- c_rd_addr  out  AW  C-memory read address (row*N + col)
- c_rd_data  in  DW  C-memory read data, valid exactly 1 cycle after c_rd_en
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts element
- out_data  out  DW  signed element value
- out_row  out  3  row index of out_data
- out_col  out  3  column index of out_data
- out_last  out  1  high with the element at (N-1, N-1)
- busy  out  1  drain in progress
- drained  out  1  one-cycle pulse after the final handshake
- checksum  out  SW  signed sum of all elements sent, held until the next drain
- drain_cycles  out  CW  cycles from drain start to drained, held until the next drain

Behaviour:
- Reset (rst_n low, asynchronous) sets every output and register to 0 and the state to IDLE: c_rd_en, c_rd_addr, out_valid, out_data, out_row, out_col, out_last, busy, drained, checksum, drain_cycles.
- Edge detect: mm_done is registered. A drain starts only on its 0->1 transition seen in IDLE.
  - mm_done held high after a drain does not retrigger. It must fall and rise again.
  - A rising edge of mm_done while busy is ignored.
- State IDLE: on a start edge, clear idx, checksum and drain_cycles; set busy=1; go to FETCH.
- State FETCH: drive c_rd_en=1 and c_rd_addr=idx for one cycle; go to WAIT.
- State WAIT: capture c_rd_data into out_data; set out_row=idx[5:3], out_col=idx[2:0], out_last=(idx==N*N-1), out_valid=1; go to SEND.
- State SEND: hold out_valid, out_data, out_row, out_col and out_last stable until out_valid and out_ready are both high.
  - On the handshake: checksum += sign-extended out_data; out_valid=0.
  - If out_last, go to FIN. Otherwise idx++ and go to FETCH.
- State FIN: drained=1 for exactly one cycle; busy=0; go to IDLE.
- Timing:
  - Minimum 3 cycles per element with out_ready tied high.
  - drain_cycles increments every cycle that busy=1, including the FIN cycle, and saturates at 2^CW-1.
  - With out_ready=1 a full drain gives drain_cycles = 193.
- out_ready high while out_valid=0 has no effect.
- idx never wraps in normal operation; the (N-1, N-1) element always terminates the drain.
- checksum arithmetic is signed, SW bits, with no overflow possible for N=8 and DW=19.
- Reset mid-drain aborts immediately. No partial drained pulse; outputs return to 0.
- c_rd_en is high only in FETCH; no reads are issued in any other state.

Decomposition:
- Shared package holds the state enum (IDLE, FETCH, WAIT, SEND, FIN), N, DW, AW, SW and the LAST_IDX = N*N-1 constant.
  - The same package is reused by the multiplier and the upstream loader.
- No sub-module is needed beyond a small rise_detect helper for mm_done, which is also reusable for the start input.

Test Plan:
- All 64 C entries = 1, out_ready=1, pulse mm_done -> 64 handshakes in row-major order; out_last only on beat 64 (row 7, col 7); checksum=64; drained pulses once; drain_cycles=193.
- C[k]=k-32 for k=0..63, out_ready=1 -> out_data sequence -32..31; checksum=-32; row/col tags match k/8, k%8.
- All entries = -262144 (19-bit minimum) -> checksum = -16777216 with no wrap; out_data is sign-correct on every beat.
- Same data as the first test, out_ready toggling 1,0,0,1 -> out_data/row/col/last stable while stalled; identical 64-beat sequence; drain_cycles > 193.
- mm_done held high for 500 cycles after the drain -> exactly one drain. Lower mm_done, raise it again -> second full drain with checksum recomputed from 0.
- rst_n asserted low at beat 20 of a drain -> all outputs 0 asynchronously with no drained pulse; next mm_done rise restarts from (0,0).

Source files
------------

// File: rtl/matc_stream_out_pkg.sv
// Shared constants and state encoding for the 8x8 matrix-multiply datapath
// (loader, multiplier and the C-matrix drain stage).
package matc_stream_out_pkg;

   localparam int N  = 8;
   localparam int DW = 19;
   localparam int AW = 6;
   localparam int SW = 25;
   localparam int CW = 11;
   localparam int RW = 3;

   localparam logic [AW-1:0] LAST_IDX = AW'(N*N-1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      SEND,
      FIN
   } state_t;

endpackage

// File: rtl/matc_stream_out_rise_detect.sv
// Registers a level input twice and flags its 0->1 transition for one cycle.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_q1;
   logic d_q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q1 <= 1'b0;
         d_q2 <= 1'b0;
      end else begin
         d_q1 <= d;
         d_q2 <= d_q1;
      end
   end

   assign rise = d_q1 & ~d_q2;

endmodule

// File: rtl/matc_stream_out.sv
// Drains the 64-entry C matrix in row-major order onto a valid/ready stream,
// accumulating a signed checksum and the number of busy cycles.
//
// state | meaning
// IDLE  | waiting for a rising edge of mm_done
// FETCH | read strobe issued for element idx
// WAIT  | read data arrives, loaded into the output register
// SEND  | element offered downstream until out_ready
// FIN   | drained pulse, busy drops on exit
module matc_stream_out
   import matc_stream_out_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mm_done,
   output logic          c_rd_en,
   output logic [AW-1:0] c_rd_addr,
   input  logic [DW-1:0] c_rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [2:0]    out_row,
   output logic [2:0]    out_col,
   output logic          out_last,
   output logic          busy,
   output logic          drained,
   output logic [SW-1:0] checksum,
   output logic [CW-1:0] drain_cycles
);

   localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

   state_t        state;
   logic [AW-1:0] idx;
   logic          start;
   logic [SW-1:0] data_sext;

   rise_detect u_done_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (mm_done),
      .rise  (start)
   );

   assign data_sext = {{(SW-DW){out_data[DW-1]}}, out_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         c_rd_en      <= 1'b0;
         c_rd_addr    <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_row      <= '0;
         out_col      <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         drained      <= 1'b0;
         checksum     <= '0;
         drain_cycles <= '0;
      end else begin
         c_rd_en <= 1'b0;
         drained <= 1'b0;
         if (busy && (drain_cycles != CYC_MAX))
            drain_cycles <= drain_cycles + 1'b1;

         unique case (state)
            IDLE: begin
               // start edges arriving outside IDLE are simply dropped
               if (start) begin
                  idx          <= '0;
                  checksum     <= '0;
                  drain_cycles <= '0;
                  busy         <= 1'b1;
                  c_rd_en      <= 1'b1;
                  c_rd_addr    <= '0;
                  state        <= FETCH;
               end
            end
            FETCH: begin
               state <= WAIT;
            end
            WAIT: begin
               out_data  <= c_rd_data;
               out_row   <= idx[AW-1:RW];
               out_col   <= idx[RW-1:0];
               out_last  <= (idx == LAST_IDX);
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (out_valid && out_ready) begin
                  checksum  <= checksum + data_sext;
                  out_valid <= 1'b0;
                  if (out_last) begin
                     drained <= 1'b1;
                     state   <= FIN;
                  end else begin
                     idx       <= idx + 1'b1;
                     c_rd_en   <= 1'b1;
                     c_rd_addr <= idx + 1'b1;
                     state     <= FETCH;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
